mul_long_seq: RTL and testbench

- Parametrised iterative multiply sequencer for the multicycle ARM datapath. It executes MUL, UMULL and SMULL as a multi-cycle side operation started by the controller.
- Generalises the controller's single-cycle MUL/UMULL/SMULL ALU decode in three ways: configurable operand width, configurable radix (bits retired per cycle), and two-beat RdLo/RdHi write-back.
- Performs its own condition check and produces flag-update results.
- Sits between the decoder and the register-file write port.

---
 rtl/mul_long_seq.sv | 108 ++++++++++
 tb/tb_mul_long_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_long_seq.sv
// mul_long_seq: iterative MUL/UMULL/SMULL sequencer with condition check, two-beat write-back and N/Z results
module mul_long_seq #(
  parameter int WIDTH = 32,
  parameter int BPC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             setflags,
  input  logic [3:0]       cond,
  input  logic [3:0]       flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             wr_en,
  output logic             wr_sel,
  output logic [WIDTH-1:0] wr_data,
  output logic             flags_we,
  output logic [1:0]       nz_out,
  output logic             done,
  output logic             illegal
);
  localparam int NITER = WIDTH / BPC;
  localparam int CW = $clog2(NITER + 1);
  typedef enum logic [2:0] {IDLE, RUN, WLO, WHI, SKIP} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH+BPC-1:0] pp, sum;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic sf_q, neg, ill_q, cond_ok, smul;
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  assign smul = op == 2'b10;
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = !z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = !c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = !n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = !v;
      4'h8: cond_ok = c && !z;
      4'h9: cond_ok = !c || z;
      4'ha: cond_ok = n == v;
      4'hb: cond_ok = n != v;
      4'hc: cond_ok = !z && (n == v);
      4'hd: cond_ok = z || (n != v);
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (op == 2'b11 || !cond_ok) ? SKIP : RUN;
      RUN: if (cnt == CW'(1)) state_nx = WLO;
      WLO: state_nx = op_q == 2'b00 ? IDLE : WHI;
      default: state_nx = IDLE;
    endcase
  end
  // Radix-2^BPC shift-add: multiplier occupies the low half and drains out LSB first
  assign pp = {{BPC{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc[BPC-1:0]};
  assign sum = {{BPC{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc <= '0;
      mcand <= '0;
      cnt <= '0;
      op_q <= '0;
      sf_q <= 1'b0;
      neg <= 1'b0;
      ill_q <= 1'b0;
    end else if (state == IDLE && start) begin
      op_q <= op;
      sf_q <= setflags;
      ill_q <= op == 2'b11;
      if (state_nx == RUN) begin
        mcand <= (smul && a[WIDTH-1]) ? -a : a;
        acc <= {{WIDTH{1'b0}}, (smul && b[WIDTH-1]) ? -b : b};
        cnt <= CW'(NITER);
        neg <= smul && (a[WIDTH-1] ^ b[WIDTH-1]);
      end
    end else if (state == RUN) begin
      acc <= (2*WIDTH)'({sum, acc[WIDTH-1:0]} >> BPC);
      cnt <= cnt - CW'(1);
    end
  assign prod = neg ? -acc : acc;
  always_comb begin
    busy = state != IDLE;
    wr_en = state == WLO || state == WHI;
    wr_sel = state == WHI;
    wr_data = state == WLO ? prod[WIDTH-1:0] : state == WHI ? prod[2*WIDTH-1:WIDTH] : '0;
    done = (state == WLO && op_q == 2'b00) || state == WHI || state == SKIP;
    flags_we = sf_q && done && state != SKIP;
    nz_out = state == WHI ? {prod[2*WIDTH-1], prod == '0} :
             (state == WLO && op_q == 2'b00) ? {prod[WIDTH-1], prod[WIDTH-1:0] == '0} : 2'b00;
    illegal = state == SKIP && ill_q;
  end
endmodule

// File: tb/tb_mul_long_seq.sv
// tb_mul_long_seq: directed checks of mul_long_seq at 32x1 and 16x4 configurations
module tb_mul_long_seq;
  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, setflags = 1'b0;
  logic [1:0] op = '0;
  logic [3:0] cond = '0, flags = '0;
  logic [31:0] a = '0, b = '0, wr_data;
  logic busy, wr_en, wr_sel, flags_we, done, illegal;
  logic [1:0] nz_out;
  logic start2 = 1'b0, setflags2 = 1'b0;
  logic [1:0] op2 = '0;
  logic [15:0] a2 = '0, b2 = '0, wr_data2;
  logic busy2, wr_en2, wr_sel2, flags_we2, done2, illegal2;
  logic [1:0] nz_out2;
  int nchecks = 0, nerr = 0;

  always #5 clk = ~clk;

  mul_long_seq #(.WIDTH(32), .BPC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .setflags(setflags), .cond(cond), .flags(flags),
    .a(a), .b(b), .busy(busy), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .flags_we(flags_we),
    .nz_out(nz_out), .done(done), .illegal(illegal));

  mul_long_seq #(.WIDTH(16), .BPC(4)) dut16 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .setflags(setflags2), .cond(4'he), .flags(4'h0),
    .a(a2), .b(b2), .busy(busy2), .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_data(wr_data2), .flags_we(flags_we2),
    .nz_out(nz_out2), .done(done2), .illegal(illegal2));

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulses start for one cycle; returns at cycle 1 relative to the start cycle
  task automatic go32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] cd, input logic [3:0] fl, input logic s);
    op = o; a = x; b = y; cond = cd; flags = fl; setflags = s; start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
  endtask

  task automatic go16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    op2 = o; a2 = x; b2 = y; setflags2 = 1'b0; start2 = 1'b1;
    wait_cyc(1);
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    wait_cyc(3);
    nchecks++;
    if ({busy, wr_en, wr_sel, flags_we, done, illegal, nz_out, wr_data} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got busy=%b wr_en=%b done=%b illegal=%b wr_data=%h, expected all zero",
               busy, wr_en, done, illegal, wr_data);
    end
    reset = 1'b1;
    wait_cyc(1);
  endtask

  task automatic test_mul;
    go32(2'b00, 32'd7, 32'd6, 4'he, 4'h0, 1'b1);
    wait_cyc(31);
    nchecks++;
    if ({busy, done, wr_en} !== 3'b100) begin
      nerr++;
      $display("FAIL mul_c32 got busy=%b done=%b wr_en=%b, expected 1/0/0", busy, done, wr_en);
    end
    wait_cyc(1);
    nchecks++;
    if ({wr_en, wr_sel, wr_data, flags_we, nz_out, done} !== {1'b1, 1'b0, 32'h2a, 1'b1, 2'b00, 1'b1}) begin
      nerr++;
      $display("FAIL mul_c33 got wr_en=%b sel=%b data=%h fwe=%b nz=%b done=%b, expected 1 0 0000002a 1 00 1",
               wr_en, wr_sel, wr_data, flags_we, nz_out, done);
    end
    wait_cyc(1);
    nchecks++;
    if ({busy, done, wr_en} !== 3'b000) begin
      nerr++;
      $display("FAIL mul_c34 got busy=%b done=%b wr_en=%b, expected 0/0/0", busy, done, wr_en);
    end
  endtask

  task automatic test_mul_flags;
    logic [31:0] xa[3] = '{32'hffffffff, 32'h80000000, 32'h00010000};
    logic [31:0] xb[3] = '{32'd1, 32'd2, 32'h00010000};
    logic [31:0] xd[3] = '{32'hffffffff, 32'h0, 32'h0};
    logic [1:0] xn[3] = '{2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 3; i++) begin
      go32(2'b00, xa[i], xb[i], 4'he, 4'h0, 1'b1);
      wait_cyc(32);
      nchecks++;
      if ({done, flags_we, wr_data, nz_out} !== {1'b1, 1'b1, xd[i], xn[i]}) begin
        nerr++;
        $display("FAIL mul_flags[%0d] got done=%b fwe=%b data=%h nz=%b, expected 1 1 %h %b",
                 i, done, flags_we, wr_data, nz_out, xd[i], xn[i]);
      end
      wait_cyc(1);
    end
  endtask

  task automatic test_umull;
    go32(2'b01, 32'hffffffff, 32'hffffffff, 4'he, 4'h0, 1'b0);
    wait_cyc(32);
    nchecks++;
    if ({wr_en, wr_sel, wr_data, done} !== {1'b1, 1'b0, 32'h1, 1'b0}) begin
      nerr++;
      $display("FAIL umull_lo got wr_en=%b sel=%b data=%h done=%b, expected 1 0 00000001 0", wr_en, wr_sel, wr_data, done);
    end
    wait_cyc(1);
    nchecks++;
    if ({wr_en, wr_sel, wr_data, done, flags_we} !== {1'b1, 1'b1, 32'hfffffffe, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL umull_hi got wr_en=%b sel=%b data=%h done=%b fwe=%b, expected 1 1 fffffffe 1 0",
               wr_en, wr_sel, wr_data, done, flags_we);
    end
    wait_cyc(1);
    nchecks++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL umull_busy_c35 got %b, expected 0", busy);
    end
  endtask

  task automatic test_smull;
    go32(2'b10, 32'hfffffffe, 32'd3, 4'he, 4'h0, 1'b1);
    wait_cyc(32);
    nchecks++;
    if ({wr_en, wr_sel, wr_data, done, flags_we} !== {1'b1, 1'b0, 32'hfffffffa, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL smull_lo got wr_en=%b sel=%b data=%h done=%b fwe=%b, expected 1 0 fffffffa 0 0",
               wr_en, wr_sel, wr_data, done, flags_we);
    end
    wait_cyc(1);
    nchecks++;
    if ({wr_sel, wr_data, done, flags_we, nz_out} !== {1'b1, 32'hffffffff, 1'b1, 1'b1, 2'b10}) begin
      nerr++;
      $display("FAIL smull_hi got sel=%b data=%h done=%b fwe=%b nz=%b, expected 1 ffffffff 1 1 10",
               wr_sel, wr_data, done, flags_we, nz_out);
    end
    wait_cyc(1);
    go32(2'b10, 32'h0, 32'hfffffffb, 4'he, 4'h0, 1'b1);
    wait_cyc(33);
    nchecks++;
    if ({wr_data, done, nz_out} !== {32'h0, 1'b1, 2'b01}) begin
      nerr++;
      $display("FAIL smull_zero got data=%h done=%b nz=%b, expected 00000000 1 01", wr_data, done, nz_out);
    end
    wait_cyc(1);
    go32(2'b10, 32'h80000000, 32'h80000000, 4'he, 4'h0, 1'b0);
    wait_cyc(33);
    nchecks++;
    if ({wr_data, done} !== {32'h40000000, 1'b1}) begin
      nerr++;
      $display("FAIL smull_minmin got data=%h done=%b, expected 40000000 1", wr_data, done);
    end
    wait_cyc(1);
  endtask

  task automatic test_cond;
    logic [3:0] ct[18] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                           4'h8, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'hd, 4'hf};
    logic [3:0] ft[18] = '{4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000, 4'b0000,
                           4'b0010, 4'b0110, 4'b0000, 4'b1001, 4'b1000, 4'b0000, 4'b0100, 4'b1001, 4'b0000};
    logic pt[18] = '{0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 18; i++) begin
      go32(2'b00, 32'd1, 32'd1, ct[i], ft[i], 1'b1);
      nchecks++;
      if ({busy, done, wr_en, flags_we, illegal} !== {1'b1, !pt[i], 3'b000}) begin
        nerr++;
        $display("FAIL cond[%0d] cond=%h flags=%b got busy=%b done=%b wr_en=%b fwe=%b ill=%b, expected 1 %b 0 0 0",
                 i, ct[i], ft[i], busy, done, wr_en, flags_we, illegal, !pt[i]);
      end
      wait_cyc(pt[i] ? 33 : 1);
    end
    nchecks++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL cond_idle got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_illegal;
    go32(2'b11, 32'd3, 32'd3, 4'he, 4'h0, 1'b1);
    nchecks++;
    if ({illegal, done, wr_en, flags_we} !== 4'b1100) begin
      nerr++;
      $display("FAIL illegal_c1 got ill=%b done=%b wr_en=%b fwe=%b, expected 1 1 0 0", illegal, done, wr_en, flags_we);
    end
    wait_cyc(1);
    nchecks++;
    if ({illegal, done, busy} !== 3'b000) begin
      nerr++;
      $display("FAIL illegal_c2 got ill=%b done=%b busy=%b, expected 0 0 0", illegal, done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int nd = 0;
    logic hs = 1'b0;
    logic [31:0] wd = '0;
    go32(2'b00, 32'd3, 32'd5, 4'he, 4'h0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (done) nd++;
      if (wr_en) wd = wr_data;
      hs |= wr_sel;
      start = k == 5;
      op = 2'b01; a = 32'd9; b = 32'd9;
      wait_cyc(1);
    end
    start = 1'b0;
    nchecks++;
    if ({nd, wd, hs} !== {32'd1, 32'd15, 1'b0}) begin
      nerr++;
      $display("FAIL start_while_busy got dones=%0d data=%h hi_write=%b, expected 1 0000000f 0", nd, wd, hs);
    end
  endtask

  task automatic test_reset_abort;
    int nw = 0;
    go32(2'b01, 32'hffffffff, 32'd2, 4'he, 4'h0, 1'b1);
    wait_cyc(9);
    reset = 1'b0;
    #1;
    nchecks++;
    if ({busy, wr_en, done} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_abort got busy=%b wr_en=%b done=%b, expected 0 0 0", busy, wr_en, done);
    end
    wait_cyc(2);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (wr_en || done) nw++;
      wait_cyc(1);
    end
    nchecks++;
    if (nw !== 0) begin
      nerr++;
      $display("FAIL reset_no_write got %0d write/done cycles, expected 0", nw);
    end
    test_mul;
  endtask

  task automatic test_w16;
    go16(2'b01, 16'h1234, 16'h5678);
    wait_cyc(4);
    nchecks++;
    if ({wr_en2, wr_sel2, wr_data2, done2} !== {1'b1, 1'b0, 16'h0060, 1'b0}) begin
      nerr++;
      $display("FAIL w16_lo got wr_en=%b sel=%b data=%h done=%b, expected 1 0 0060 0", wr_en2, wr_sel2, wr_data2, done2);
    end
    wait_cyc(1);
    nchecks++;
    if ({wr_en2, wr_sel2, wr_data2, done2} !== {1'b1, 1'b1, 16'h0626, 1'b1}) begin
      nerr++;
      $display("FAIL w16_hi got wr_en=%b sel=%b data=%h done=%b, expected 1 1 0626 1", wr_en2, wr_sel2, wr_data2, done2);
    end
    wait_cyc(1);
    go16(2'b10, 16'h8000, 16'h8000);
    wait_cyc(5);
    nchecks++;
    if ({wr_sel2, wr_data2, done2} !== {1'b1, 16'h4000, 1'b1}) begin
      nerr++;
      $display("FAIL w16_smull_hi got sel=%b data=%h done=%b, expected 1 4000 1", wr_sel2, wr_data2, done2);
    end
    wait_cyc(1);
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mul_flags;
    test_umull;
    test_smull;
    test_cond;
    test_illegal;
    test_back_to_back;
    test_reset_abort;
    test_w16;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
